fifo: RTL and testbench



---
 rtl/fifo.sv | 77 +++++++
 tb/tb_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data.
// Occupancy is tracked in an explicit count, so any FIFO_DEPTH >= 2 works,
// including non-powers of two. The full and empty flags are decoded
// directly from that count.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  do_wr;
  logic                  do_rd;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_nxt;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A write while full is accepted only when a read frees the slot on the same edge.
  assign do_rd = read_en && !empty;
  assign do_wr = write_en && (!full || read_en);

  // Next pointer values, wrapping at FIFO_DEPTH-1 because the depth need not be a power of two.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (do_wr) wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
    if (do_rd) rd_ptr_nxt = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is left out of reset. Stale words cannot be read, because count gates every read.
    if (do_wr && !rst) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and registered read data. Reset takes priority over any request.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (do_rd) data_out <= mem[rd_ptr];
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed testbench for fifo (DATA_WIDTH=8, FIFO_DEPTH=16).
// Expected values are hand-derived from the FIFO ordering rules.
module tb_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;

  int checks = 0;
  int errors = 0;

  fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%0d exp=0", data_out); end
  endtask

  task automatic test_fill();
    write_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = DW'(10 + i);
      tick();
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
      checks++; if (full !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == DEPTH - 1)); end
    end
    write_en = 1'b0;
  endtask

  task automatic test_drain();
    read_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++; if (data_out !== DW'(10 + i)) begin errors++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", i, data_out, 10 + i); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d] got=%b exp=0", i, full); end
      checks++; if (empty !== (i == DEPTH - 1)) begin errors++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, (i == DEPTH - 1)); end
    end
    read_en = 1'b0;
  endtask

  task automatic test_read_empty();
    read_en = 1'b1;
    tick(); tick();
    read_en = 1'b0;
    checks++; if (data_out !== 8'd25) begin errors++; $display("FAIL rdempty_data got=%0d exp=25", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rdempty_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rdempty_full got=%b exp=0", full); end
  endtask

  // Start empty. The first edge accepts only the write; after that each read returns the previous write.
  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    write_en = 1'b1; read_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = DW'(100 + i);
      exp = (i == 0) ? DW'(25) : DW'(99 + i);
      tick();
      checks++; if (data_out !== exp) begin errors++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, data_out, exp); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL b2b_empty[%0d] got=%b exp=0", i, empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL b2b_full[%0d] got=%b exp=0", i, full); end
    end
    write_en = 1'b0; read_en = 1'b0;
  endtask

  // The FIFO holds 104 at this point. Add 200..214 to fill it, then test the dropped write and the write+read at full.
  task automatic test_full_boundary();
    logic [DW-1:0] exp;
    write_en = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      data_in = DW'(200 + i);
      tick();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_reached got=%b exp=1", full); end
    data_in = 8'hAA;
    tick();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL drop_full got=%b exp=1", full); end
    checks++; if (data_out !== 8'd103) begin errors++; $display("FAIL drop_data got=%0d exp=103", data_out); end
    data_in = 8'hBB; read_en = 1'b1;
    tick();
    checks++; if (data_out !== 8'd104) begin errors++; $display("FAIL fullrw_data got=%0d exp=104", data_out); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullrw_full got=%b exp=1", full); end
    write_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i == DEPTH - 1) ? 8'hBB : DW'(200 + i);
      tick();
      checks++; if (data_out !== exp) begin errors++; $display("FAIL fulldrain_data[%0d] got=%0d exp=%0d", i, data_out, exp); end
    end
    read_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fulldrain_empty got=%b exp=1", empty); end
  endtask

  // Reset in the middle of traffic. A write requested on the reset edge must be ignored.
  task automatic test_mid_reset();
    write_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_in = DW'(i);
      tick();
    end
    read_en = 1'b1;
    tick();
    checks++; if (data_out !== 8'd1) begin errors++; $display("FAIL prereset_data got=%0d exp=1", data_out); end
    rst = 1'b1; read_en = 1'b0; data_in = 8'h77;
    tick();
    rst = 1'b0; write_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full got=%b exp=0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got=%0d exp=0", data_out); end
    write_en = 1'b1; data_in = 8'h5A;
    tick();
    write_en = 1'b0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL postrst_wr_empty got=%b exp=0", empty); end
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL postrst_data got=%0d exp=90", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL postrst_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_read_empty();
    test_back_to_back();
    test_full_boundary();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
